chunked_addsub_seq: RTL and testbench

- Parametrised, multi-cycle successor to the 8-bit combinational ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a register.
- Reports sum, carry-out and an overflow flag valid for unsigned or two's-complement interpretation.
- Sits between an operand producer and a result consumer with valid/ready handshakes on both sides; trades latency for a short carry chain.

---
 rtl/chunked_addsub_seq.sv | 133 +++++++++++++
 tb/tb_chunked_addsub_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_addsub_seq.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock with a
// registered carry between chunks, valid/ready handshakes on both sides.
module chunked_addsub_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mode,
    input  logic             signed_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
        $error("chunked_addsub_seq: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             mode_reg;
    logic             signed_reg;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] chunk_sum;
    logic             carry_next;
    logic             ovf_next;
    logic             last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (state == CALC) && (cnt == LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = CALC;
            CALC:    if (cnt == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Select the current chunk of both operands and add it with the carry
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cnt == CNT_W'(i)) begin
                a_chunk = a_reg[i*CHUNK +: CHUNK];
                b_chunk = b_reg[i*CHUNK +: CHUNK];
            end
        end
        {carry_next, chunk_sum} = {1'b0, a_chunk} + {1'b0, b_chunk}
                                + (CHUNK + 1)'(carry);
        // The last chunk holds the MSB, so its top bit is the final sum sign
        if (signed_reg)
            ovf_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                    && (chunk_sum[CHUNK-1] != a_reg[WIDTH-1]);
        else
            ovf_next = mode_reg ? carry_next : ~carry_next;
    end

    // Operand capture, per-chunk accumulation and final flag update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            mode_reg   <= 1'b0;
            signed_reg <= 1'b0;
            cnt        <= '0;
            carry      <= 1'b0;
            sum        <= '0;
            c_out      <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg      <= A;
                        b_reg      <= mode ? B : ~B;
                        mode_reg   <= mode;
                        signed_reg <= signed_op;
                        carry      <= ~mode;
                        cnt        <= '0;
                    end
                end
                CALC: begin
                    for (int unsigned i = 0; i < N; i++) begin
                        if (cnt == CNT_W'(i)) sum[i*CHUNK +: CHUNK] <= chunk_sum;
                    end
                    carry <= carry_next;
                    if (last) begin
                        c_out <= carry_next;
                        ovf   <= ovf_next;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_addsub_seq.sv
// Directed self-checking bench for chunked_addsub_seq (8/2, 16/4, 8/8).
module tb_chunked_addsub_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // WIDTH=8, CHUNK=2
    logic       d0_in_valid = 0, d0_in_ready, d0_mode = 0, d0_sgn = 0;
    logic       d0_out_valid, d0_out_ready = 0, d0_c_out, d0_ovf;
    logic [7:0] d0_a = 0, d0_b = 0, d0_sum;

    // WIDTH=16, CHUNK=4
    logic        d1_in_valid = 0, d1_in_ready, d1_mode = 0, d1_sgn = 0;
    logic        d1_out_valid, d1_out_ready = 0, d1_c_out, d1_ovf;
    logic [15:0] d1_a = 0, d1_b = 0, d1_sum;

    // WIDTH=8, CHUNK=8
    logic       d2_in_valid = 0, d2_in_ready, d2_mode = 0, d2_sgn = 0;
    logic       d2_out_valid, d2_out_ready = 0, d2_c_out, d2_ovf;
    logic [7:0] d2_a = 0, d2_b = 0, d2_sum;

    chunked_addsub_seq #(.WIDTH(8), .CHUNK(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
        .A(d0_a), .B(d0_b), .mode(d0_mode), .signed_op(d0_sgn),
        .out_valid(d0_out_valid), .out_ready(d0_out_ready),
        .sum(d0_sum), .c_out(d0_c_out), .ovf(d0_ovf));

    chunked_addsub_seq #(.WIDTH(16), .CHUNK(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .A(d1_a), .B(d1_b), .mode(d1_mode), .signed_op(d1_sgn),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .sum(d1_sum), .c_out(d1_c_out), .ovf(d1_ovf));

    chunked_addsub_seq #(.WIDTH(8), .CHUNK(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .A(d2_a), .B(d2_b), .mode(d2_mode), .signed_op(d2_sgn),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready),
        .sum(d2_sum), .c_out(d2_c_out), .ovf(d2_ovf));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present operands to dut0, then count edges until out_valid rises
    task automatic d0_start(input logic [7:0] a, input logic [7:0] b,
                            input logic md, input logic sg, output int lat);
        @(negedge clk);
        check("d0_in_ready_before", 32'(d0_in_ready), 1);
        d0_in_valid = 1; d0_a = a; d0_b = b; d0_mode = md; d0_sgn = sg;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs: in-flight operation must ignore them
        d0_in_valid = 0; d0_a = ~a; d0_b = a ^ b; d0_mode = ~md; d0_sgn = ~sg;
        lat = 0;
        while (!d0_out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic d0_finish();
        @(negedge clk);
        d0_out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        d0_out_ready = 0;
        check("d0_out_valid_after_hs", 32'(d0_out_valid), 0);
        check("d0_in_ready_after_hs", 32'(d0_in_ready), 1);
    endtask

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       md;
        logic       sg;
        logic [7:0] s;
        logic       c;
        logic       o;
    } vec_t;

    vec_t vecs [6] = '{
        '{8'd110, 8'd2,   1'b1, 1'b0, 8'd112, 1'b0, 1'b0},
        '{8'd127, 8'd126, 1'b1, 1'b1, 8'd253, 1'b0, 1'b1},
        '{8'd127, 8'd126, 1'b1, 1'b0, 8'd253, 1'b0, 1'b0},
        '{8'd200, 8'd100, 1'b1, 1'b0, 8'd44,  1'b1, 1'b1},
        '{8'd19,  8'd12,  1'b0, 1'b0, 8'd7,   1'b1, 1'b0},
        '{8'd12,  8'd19,  1'b0, 1'b0, 8'd249, 1'b0, 1'b1}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        #2;
        check("rst_in_ready", 32'(d0_in_ready), 1);
        check("rst_out_valid", 32'(d0_out_valid), 0);
        check("rst_sum", 32'(d0_sum), 0);
        check("rst_c_out", 32'(d0_c_out), 0);
        check("rst_ovf", 32'(d0_ovf), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        // Directed arithmetic vectors
        foreach (vecs[i]) begin
            d0_start(vecs[i].a, vecs[i].b, vecs[i].md, vecs[i].sg, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 4);
            check($sformatf("vec%0d_sum", i), 32'(d0_sum), 32'(vecs[i].s));
            check($sformatf("vec%0d_c_out", i), 32'(d0_c_out), 32'(vecs[i].c));
            check($sformatf("vec%0d_ovf", i), 32'(d0_ovf), 32'(vecs[i].o));
            d0_finish();
        end

        // Backpressure: result held, new operands refused while in DONE
        d0_start(8'd19, 8'd12, 1'b1, 1'b0, lat);
        check("bp_latency", 32'(lat), 4);
        for (int k = 0; k < 5; k++) begin
            d0_in_valid = 1; d0_a = 8'd99; d0_b = 8'd1; d0_mode = 0;
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", 32'(d0_out_valid), 1);
            check("bp_in_ready", 32'(d0_in_ready), 0);
            check("bp_sum", 32'(d0_sum), 31);
            check("bp_c_out", 32'(d0_c_out), 0);
            check("bp_ovf", 32'(d0_ovf), 0);
        end
        d0_in_valid = 0;
        d0_finish();
        check("hold_sum_idle", 32'(d0_sum), 31);
        @(negedge clk);
        check("hold_still_idle", 32'(d0_in_ready), 1);

        // Reset two cycles into CALC
        d0_in_valid = 1; d0_a = 8'd200; d0_b = 8'd100; d0_mode = 1; d0_sgn = 0;
        @(posedge clk);
        @(negedge clk);
        d0_in_valid = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("midcalc_out_valid", 32'(d0_out_valid), 0);
        check("midcalc_in_ready", 32'(d0_in_ready), 0);
        rst = 1;
        #1;
        check("midrst_sum", 32'(d0_sum), 0);
        check("midrst_in_ready", 32'(d0_in_ready), 1);
        check("midrst_out_valid", 32'(d0_out_valid), 0);
        check("midrst_c_out", 32'(d0_c_out), 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("postrst_out_valid", 32'(d0_out_valid), 0);
        d0_start(8'd19, 8'd12, 1'b1, 1'b0, lat);
        check("postrst_latency", 32'(lat), 4);
        check("postrst_sum", 32'(d0_sum), 31);
        check("postrst_c_out", 32'(d0_c_out), 0);
        check("postrst_ovf", 32'(d0_ovf), 0);
        d0_finish();

        // WIDTH=16, CHUNK=4: carry ripples through all four chunks
        @(negedge clk);
        d1_in_valid = 1; d1_a = 16'hFFFF; d1_b = 16'd1; d1_mode = 1; d1_sgn = 0;
        @(posedge clk);
        @(negedge clk);
        d1_in_valid = 0; d1_a = 16'h1234;
        lat = 0;
        while (!d1_out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("w16_latency", 32'(lat), 4);
        check("w16_sum", 32'(d1_sum), 0);
        check("w16_c_out", 32'(d1_c_out), 1);
        check("w16_ovf", 32'(d1_ovf), 1);

        // WIDTH=8, CHUNK=8: single-chunk operation
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            d2_out_ready = 0;
            d2_in_valid = 1;
            d2_a = (k == 0) ? 8'd19 : 8'd12;
            d2_b = (k == 0) ? 8'd12 : 8'd19;
            d2_mode = (k == 0);
            d2_sgn = 0;
            @(posedge clk);
            @(negedge clk);
            d2_in_valid = 0;
            lat = 0;
            while (!d2_out_valid && lat < 20) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            check("w8c8_latency", 32'(lat), 1);
            check("w8c8_sum", 32'(d2_sum), (k == 0) ? 31 : 249);
            check("w8c8_c_out", 32'(d2_c_out), (k == 0) ? 0 : 0);
            check("w8c8_ovf", 32'(d2_ovf), (k == 0) ? 0 : 1);
            d2_out_ready = 1;
            @(posedge clk);
            @(negedge clk);
            d2_out_ready = 0;
            check("w8c8_in_ready", 32'(d2_in_ready), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
